// File: rtl/adder_unit_seq.sv
// Handshaked add/subtract unit: single-cycle full-width path or a segmented path
// that adds SEG_W bits per cycle through a registered inter-segment carry.
//
//   state  | meaning
//   IDLE   | ready for an operand bundle
//   BUSY   | segmented op in flight, one segment per cycle, LSB first
//   DONE   | result and flags held until out_ready
module adder_unit_seq #(
    parameter int WIDTH = 64,
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSEG   = WIDTH / SEG_W;
    localparam int SEG_CW = (NSEG > 1) ? $clog2(NSEG) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic [SEG_CW-1:0] seg_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              zero_q;

    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH:0]    fast_full;
    logic [WIDTH-1:0]  fast_sum;
    logic              fast_ovf;
    logic [SEG_W-1:0]  seg_a;
    logic [SEG_W-1:0]  seg_b;
    logic [SEG_W:0]    seg_full;
    logic [WIDTH-1:0]  sum_next;
    logic              seg_last;
    logic              seg_ovf;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Subtraction is a + ~b + cin, so b is inverted once at accept time.
    assign b_eff     = mode[1] ? ~b : b;
    assign fast_full = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    assign fast_sum  = fast_full[WIDTH-1:0];

    // Carry-in-to-MSB XOR carry-out equals "like-signed operands, unlike-signed result".
    assign fast_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (fast_sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        seg_a    = '0;
        seg_b    = '0;
        sum_next = sum_q;
        for (int k = 0; k < NSEG; k++) begin
            if (seg_q == SEG_CW'(k)) begin
                seg_a = a_q[k*SEG_W +: SEG_W];
                seg_b = b_q[k*SEG_W +: SEG_W];
            end
        end
        seg_full = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, carry_q};
        for (int k = 0; k < NSEG; k++) begin
            if (seg_q == SEG_CW'(k)) begin
                sum_next[k*SEG_W +: SEG_W] = seg_full[SEG_W-1:0];
            end
        end
    end

    assign seg_last = (seg_q == SEG_CW'(NSEG - 1));
    assign seg_ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_next[WIDTH-1] != a_q[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            seg_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= cin;
                        seg_q   <= '0;
                        if (!mode[0]) begin
                            sum_q  <= fast_sum;
                            cout_q <= fast_full[WIDTH];
                            ovf_q  <= fast_ovf;
                            zero_q <= (fast_sum == '0);
                            state  <= S_DONE;
                        end else begin
                            state  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    sum_q   <= sum_next;
                    carry_q <= seg_full[SEG_W];
                    if (seg_last) begin
                        cout_q <= seg_full[SEG_W];
                        ovf_q  <= seg_ovf;
                        zero_q <= (sum_next == '0);
                        state  <= S_DONE;
                    end else begin
                        seg_q  <= seg_q + SEG_CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_unit_seq.sv
// Directed and randomised checks for adder_unit_seq at WIDTH=64, SEG_W=16.
module tb_adder_unit_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_unit_seq #(.WIDTH(64), .SEG_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference: {cout,sum} = a + (sub ? ~b : b) + cin; ovf = carry into MSB ^ carry out.
    function automatic logic [66:0] model(input logic [1:0] m, input logic [63:0] av,
                                          input logic [63:0] bv, input logic ci);
        logic [63:0] bx;
        logic [64:0] full;
        logic [63:0] low;
        bx   = m[1] ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bx} + 65'(ci);
        low  = {1'b0, av[62:0]} + {1'b0, bx[62:0]} + 64'(ci);
        return {full[64], low[63] ^ full[64], full[63:0] == 64'd0, full[63:0]};
    endfunction

    task automatic do_op(input string tag, input logic [1:0] m, input logic [63:0] av,
                         input logic [63:0] bv, input logic ci, input int exp_lat,
                         input logic [63:0] exp_sum, input logic ec, input logic eo,
                         input logic ez);
        int n;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        mode = m; a = av; b = bv; cin = ci; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~av; b = 64'h5A5A_A5A5_5A5A_A5A5; mode = ~m; cin = ~ci;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_sum"},  sum, exp_sum);
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"},  64'(ovf),  64'(eo));
        chk({tag, "_zero"}, 64'(zero), 64'(ez));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_rel_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_rel_in_ready"},  64'(in_ready),  64'd1);
    endtask

    initial begin
        logic [66:0] q[$];
        logic [66:0] e;
        int          accepted;
        int          cyc;
        int          sel;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; mode = 2'b00;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_sum",       sum,              64'd0);
        chk("rst_flags",     {61'd0, cout, ovf, zero}, 64'd0);
        chk("rst_out_valid", 64'(out_valid),   64'd0);
        chk("rst_in_ready",  64'(in_ready),    64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("fast_add_wrap", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1,
              64'd0, 1'b1, 1'b0, 1'b1);
        release_out("fast_add_wrap");

        do_op("seg_add_ovf", 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 5,
              64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        release_out("seg_add_ovf");

        do_op("fast_sub_neg", 2'b10, 64'd5, 64'd7, 1'b1, 1,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        release_out("fast_sub_neg");

        do_op("seg_sub_pos", 2'b11, 64'd7, 64'd5, 1'b1, 5,
              64'd2, 1'b1, 1'b0, 1'b0);
        release_out("seg_sub_pos");

        do_op("seg_sub_zero", 2'b11, 64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, 1'b1, 5,
              64'd0, 1'b1, 1'b0, 1'b1);
        release_out("seg_sub_zero");

        // Backpressure: result must hold and a second bundle must be refused.
        do_op("bp", 2'b00, 64'h1234, 64'h1, 1'b1, 1, 64'h1236, 1'b0, 1'b0, 1'b0);
        mode = 2'b00; a = 64'h9999; b = 64'h1; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_sum_hold",  sum, 64'h1236);
            chk("bp_flag_hold", {61'd0, cout, ovf, zero}, 64'd0);
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        release_out("bp");
        @(negedge clk);
        chk("bp_no_ghost", 64'(out_valid), 64'd0);

        // Reset two cycles into a segmented op.
        @(negedge clk);
        mode = 2'b01; a = 64'h1111_2222_3333_4444; b = 64'h0101_0101_0101_0101; cin = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sum",       sum, 64'd0);
        chk("mid_rst_flags",     {61'd0, cout, ovf, zero}, 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
        repeat (3) @(negedge clk);
        chk("mid_rst_held", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        do_op("post_rst", 2'b01, 64'h0000_0001_FFFF_FFFF, 64'd1, 1'b0, 5,
              64'h0000_0002_0000_0000, 1'b0, 1'b0, 1'b0);
        release_out("post_rst");

        // Random traffic against the reference model with a FIFO scoreboard.
        accepted = 0;
        cyc = 0;
        while ((accepted < 2000 || q.size() != 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (accepted < 2000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            mode      = 2'($urandom_range(0, 3));
            cin       = 1'($urandom_range(0, 1));
            sel       = $urandom_range(0, 3);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (sel == 1) b = a;
            if (sel == 2) a = 64'hFFFF_FFFF_FFFF_FFFF;
            if (sel == 3) begin a = 64'($urandom_range(0, 255)); b = 64'($urandom_range(0, 255)); end
            if (in_valid && in_ready) begin
                q.push_back(model(mode, a, b, cin));
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_duplicate", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_sum",   sum, e[63:0]);
                    chk("rnd_flags", {61'd0, cout, ovf, zero}, {61'd0, e[66:64]});
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rnd_timeout",  64'(cyc < 40000), 64'd1);
        chk("rnd_accepted", 64'(accepted), 64'd2000);
        chk("rnd_dropped",  64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
